axis_frame_source: RTL and testbench
====================================

# axis_frame_source

Synthesizable AXI4-Stream master that generates framed, signed sine-wave sample streams to drive the FIR filter's AXI4-Stream slave input in the board-level design. It replaces external stimulus, so the on-board design can self-exercise the filter from reset. A run is started by a single pulse. The block emits `num_frames` frames of `frame_len` samples each, with `tlast` on the final sample of every frame. It honours backpressure without dropping or duplicating samples.

## Interface
- `DATA_W`, 16: sample width, two's complement.
- `LUT_AW`, 8: log2 of sine table depth; phase accumulator width.
- `LEN_W`, 16: width of `frame_len`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request; sampled only in IDLE.
- `frame_len` in LEN_W: samples per frame; latched on accepted `start`.
- `num_frames` in 8: frames per run; latched on accepted `start`.
- `phase_inc` in LUT_AW: phase step per sample; latched on accepted `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of run.
- `m_axis_tdata` out DATA_W: sample.
- `m_axis_tvalid` out 1: sample valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last sample of frame.

## Operation
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, state=IDLE, phase=0, all counters=0.
- **States:**
  - IDLE: on `start`=1 with `frame_len`≠0 and `num_frames`≠0, latch the parameters, clear phase and counters, and go to RUN. On `start` with a zero length or zero frame count, pulse `done` next cycle with no beats and stay in IDLE.
  - RUN: issue table reads at the current phase and advance phase by `phase_inc` modulo 2^LUT_AW. Phase is continuous across frame boundaries. After issuing the final sample of the final frame, go to DRAIN.
  - DRAIN: wait until every issued sample has completed a handshake. Then pulse `done`, drop `busy`, and go to IDLE.
- `start` is ignored while `busy`=1.
- **Table contents:** entry k = round((2^(DATA_W-1)−1)·sin(2πk/2^LUT_AW)). The table never contains −2^(DATA_W-1).
- **Framing:** the sample counter runs 0..`frame_len`−1. `tlast`=1 exactly on index `frame_len`−1. The frame counter increments at each frame end.
- **Backpressure:** the output stage is an output register plus a one-entry skid register, which absorbs the one-cycle table latency. A new read is issued only when a free slot is guaranteed.
- **AXI-Stream rules:** once `tvalid` is asserted, `tvalid`, `tdata` and `tlast` stay stable until the handshake (`tvalid`&&`tready`). `tvalid` never depends combinationally on `tready`.
- **Reset mid-run:** abandon immediately, return all outputs to their reset values, no `done` pulse.

## Timing
- `start` accepted at edge E0 → `busy`=1 after E0. The first read is issued in cycle E0..E1, and `tvalid`=1 after E2.
- With `tready` held at 1: one beat per cycle, no bubbles, including across frame boundaries.
- `tready` low for N cycles: output holds its sample. When `tready` returns high, beats resume with the next sample in sequence, no gaps beyond one cycle.
- The final handshake occurs at edge Ef → `done`=1 and `busy`=0 for the cycle after Ef. `tvalid`=0 from the same edge.
- A new `start` is accepted at the earliest on the edge after the `done` pulse.

## Structure
- **Package `axis_src_pkg`:** state enum (IDLE, RUN, DRAIN), default widths, amplitude constant 2^(DATA_W-1)−1.
- **Sub-module `sine_lut`:** full-wave table with one-cycle registered read, initialised at elaboration. Everything else lives in `axis_frame_source`: FSM, counters, phase accumulator, skid buffer.

## Test plan
- **Basic run:** DATA_W=16, LUT_AW=8, `phase_inc`=64, `frame_len`=4, `num_frames`=2, `tready`=1.
  - Beats: 0, 32767, 0, −32767, repeated twice.
  - `tlast` on beats 3 and 7.
  - `done` one cycle after beat 7; first `tvalid` two cycles after `start`.
- **Backpressure:** same run with `tready` toggled pseudo-randomly → identical beat sequence and `tlast` positions, `tdata` stable while stalled, no loss or duplication.
- **Odd lengths:** `frame_len`=3, `num_frames`=3, `phase_inc`=64 → continuous phase: 0, 32767, 0 | −32767, 0, 32767 | 0, −32767, 0, with `tlast` every 3rd beat.
- **Degenerate starts:**
  - `frame_len`=0 → `done` the next cycle, `tvalid` never asserted.
  - `start` pulsed while `busy` → ignored, original run completes unchanged.
- **Reset mid-run:** `reset` asserted after beat 2 of a 16-beat run → next cycle `tvalid`=0, `busy`=0, no `done`. A fresh `start` then begins again at sample 0.
- **Wrap-around:** `phase_inc`=255, `frame_len`=3 → table entries 0, 255, 254.
  - Beats: 0, −804, −1608 (±1).

Source files
------------

// File: rtl/axis_src_pkg.sv
// Shared types and defaults for the AXI4-Stream sine frame source.
package axis_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LUT_AW = 8;
    localparam int DEF_LEN_W  = 16;

    localparam real SINE_PI = 3.14159265358979323846;

    // Peak sine amplitude; symmetric so the most negative code is never produced.
    function automatic int sine_amp(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-wave signed sine table with a one-cycle registered read.
// Contents are computed at elaboration from the amplitude constant.
module sine_lut
    import axis_src_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LUT_AW = DEF_LUT_AW
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [DATA_W-1:0] rom_w [DEPTH];
    logic [DATA_W-1:0] data_q;

    // Round half away from zero so the table is symmetric about zero.
    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        real x;
        int  v;
        x = $itor(sine_amp(DATA_W)) * $sin(2.0 * SINE_PI * $itor(k) / $itor(DEPTH));
        if (x >= 0.0) begin
            v = $rtoi(x + 0.5);
        end else begin
            v = -$rtoi(0.5 - x);
        end
        return DATA_W'(v);
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom_w[gi] = sine_entry(gi);
    end

    // Registered table read: data follows addr by one clock.
    always_ff @(posedge clk) begin
        data_q <= rom_w[addr];
    end

    assign data = data_q;

endmodule

// File: rtl/axis_frame_source.sv
// AXI4-Stream master emitting num_frames frames of frame_len sine samples.
// Reads are issued into a one-cycle table; results land in an output
// register backed by a one-entry skid register, so a read is only issued
// when both the in-flight sample and any held samples are sure to fit.
module axis_frame_source
    import axis_src_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [7:0]        num_frames,
    input  logic [LUT_AW-1:0] phase_inc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    state_e             state_q,     state_d;
    logic [LUT_AW-1:0]  phase_q,     phase_d;
    logic [LUT_AW-1:0]  inc_q,       inc_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [LEN_W-1:0]   samp_cnt_q,  samp_cnt_d;
    logic [7:0]         nfr_q,       nfr_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               rd_valid_q,  rd_valid_d;
    logic               rd_last_q,   rd_last_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic               skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]  skid_data_q,  skid_data_d;
    logic               skid_last_q,  skid_last_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    logic [DATA_W-1:0]  lut_data;
    logic               pop;
    logic [1:0]         occ;
    logic [1:0]         occ_after;
    logic               room;
    logic               last_samp;
    logic               last_frame;

    sine_lut #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk  (clk),
        .addr (phase_q),
        .data (lut_data)
    );

    // Samples held or in flight after this cycle's handshake; one more read
    // is safe only if at most one slot of the two-deep output stage is used.
    assign pop        = out_valid_q && m_axis_tready;
    assign occ        = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};
    assign occ_after  = occ - {1'b0, pop};
    assign room       = (occ_after <= 2'd1);
    assign last_samp  = (samp_cnt_q == len_q - LEN_W'(1));
    assign last_frame = (frame_cnt_q == nfr_q - 8'd1);

    // Next-state logic: output/skid stage movement, then the run FSM.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        inc_d        = inc_q;
        len_d        = len_q;
        samp_cnt_d   = samp_cnt_q;
        nfr_d        = nfr_q;
        frame_cnt_d  = frame_cnt_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (out_valid_q && !m_axis_tready) begin
            // Stalled: output holds, an arriving read parks in the skid slot.
            if (rd_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = lut_data;
                skid_last_d  = rd_last_q;
            end
        end else if (skid_valid_q) begin
            // Output free: oldest sample (skid) moves up, arrival backfills skid.
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = rd_valid_q;
            if (rd_valid_q) begin
                skid_data_d = lut_data;
                skid_last_d = rd_last_q;
            end
        end else begin
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
                out_data_d = lut_data;
                out_last_d = rd_last_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len != '0 && num_frames != '0) begin
                        len_d       = frame_len;
                        nfr_d       = num_frames;
                        inc_d       = phase_inc;
                        phase_d     = '0;
                        samp_cnt_d  = '0;
                        frame_cnt_d = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (room) begin
                    rd_valid_d = 1'b1;
                    rd_last_d  = last_samp;
                    phase_d    = phase_q + inc_q;
                    if (last_samp) begin
                        samp_cnt_d  = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        if (last_frame) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_valid_q && !skid_valid_q && (!out_valid_q || pop)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            inc_q        <= '0;
            len_q        <= '0;
            samp_cnt_q   <= '0;
            nfr_q        <= '0;
            frame_cnt_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            inc_q        <= inc_d;
            len_q        <= len_d;
            samp_cnt_q   <= samp_cnt_d;
            nfr_q        <= nfr_d;
            frame_cnt_q  <= frame_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: a queue-based model of the
// expected beat stream plus run-level busy/done expectations, compared on
// every falling edge, with literal checks pinning the model.
module tb_axis_frame_source;

    localparam int DATA_W = 16;
    localparam int LUT_AW = 8;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  frame_len = '0;
    logic [7:0]        num_frames = '0;
    logic [LUT_AW-1:0] phase_inc = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;

    axis_frame_source #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .phase_inc     (phase_inc),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    tab [DEPTH];
    beat_t exp_q [$];
    int    cap_q [$];
    bit    capl_q [$];
    bit    rdy_mode = 1'b0;
    bit    done_seen = 1'b0;

    bit    m_busy = 1'b0;
    bit    done_pend = 1'b0;
    bit    reset_chk = 1'b0;
    bit    prev_stall = 1'b0;
    bit    prev_hs = 1'b0;
    int    prev_data = 0;
    bit    prev_last = 1'b0;
    int    first_valid_cyc = -1;
    int    cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_sine(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Ready generator: always high or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks the DUT against the model every falling edge.
    always @(negedge clk) begin
        beat_t b;
        bit    hs;
        bit    final_hs;
        int    act_data;
        int    total;
        cyc++;
        act_data = int'($signed(m_axis_tdata));
        hs       = m_axis_tvalid && m_axis_tready;
        final_hs = 1'b0;
        if (!reset) begin
            if (reset_chk) begin
                chk("rst_tvalid", int'(m_axis_tvalid), 0);
                chk("rst_tdata",  act_data, 0);
                chk("rst_tlast",  int'(m_axis_tlast), 0);
                reset_chk = 1'b0;
            end
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(done_pend));
            if (done) done_seen = 1'b1;
            if (first_valid_cyc == cyc) begin
                chk("first_valid_latency", int'(m_axis_tvalid), 1);
                first_valid_cyc = -1;
            end else if (first_valid_cyc >= 0 && m_axis_tvalid) begin
                chk("first_valid_early_cyc", cyc, first_valid_cyc);
                first_valid_cyc = -1;
            end
            if (prev_stall) begin
                chk("hold_tvalid", int'(m_axis_tvalid), 1);
                chk("hold_tdata",  act_data, prev_data);
                chk("hold_tlast",  int'(m_axis_tlast), int'(prev_last));
            end
            if (prev_hs && exp_q.size() > 0) chk("no_bubble", int'(m_axis_tvalid), 1);
            if (exp_q.size() == 0) begin
                chk("idle_tvalid", int'(m_axis_tvalid), 0);
            end else if (hs) begin
                b = exp_q.pop_front();
                chk("beat_tdata", act_data, b.data);
                chk("beat_tlast", int'(m_axis_tlast), int'(b.last));
                cap_q.push_back(act_data);
                capl_q.push_back(m_axis_tlast);
                if (exp_q.size() == 0) final_hs = 1'b1;
            end
            // Run-level model: what the next cycle must show.
            done_pend = final_hs;
            if (final_hs) m_busy = 1'b0;
            if (start && !m_busy) begin
                if (frame_len != 0 && num_frames != 0) begin
                    total = int'(frame_len) * int'(num_frames);
                    for (int i = 0; i < total; i++) begin
                        b.data = tab[(i * int'(phase_inc)) % DEPTH];
                        b.last = ((i % int'(frame_len)) == int'(frame_len) - 1);
                        exp_q.push_back(b);
                    end
                    m_busy = 1'b1;
                    first_valid_cyc = cyc + 3;
                end else begin
                    done_pend = 1'b1;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = act_data;
            prev_last  = m_axis_tlast;
            prev_hs    = hs;
        end else begin
            exp_q.delete();
            m_busy          = 1'b0;
            done_pend       = 1'b0;
            reset_chk       = 1'b1;
            first_valid_cyc = -1;
            prev_stall      = 1'b0;
            prev_hs         = 1'b0;
        end
    end

    task automatic pulse_start(input int len, input int nfr, input int inc);
        @(posedge clk);
        #1;
        frame_len  = LEN_W'(len);
        num_frames = 8'(nfr);
        phase_inc  = LUT_AW'(inc);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("done_within_budget", int'(done_seen), 1);
    endtask

    task automatic wait_beats(input int cnt, input int budget);
        int n = 0;
        while (cap_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("beats_within_budget", int'(cap_q.size() >= cnt), 1);
    endtask

    task automatic run_case(input int len, input int nfr, input int inc, input bit mode);
        cap_q.delete();
        capl_q.delete();
        done_seen = 1'b0;
        rdy_mode  = mode;
        pulse_start(len, nfr, inc);
        wait_done(40 + 8 * len * nfr);
        chk("beat_count", cap_q.size(), len * nfr);
        $display("run len=%0d frames=%0d inc=%0d random_ready=%0d beats=%0d", len, nfr, inc, mode, cap_q.size());
    endtask

    task automatic check_seq(input string name, input int lits[9], input int n, input int last_every);
        for (int i = 0; i < n; i++) begin
            if (i < cap_q.size()) begin
                chk({name, "_data"}, cap_q[i], lits[i]);
                chk({name, "_last"}, int'(capl_q[i]), int'((i % last_every) == last_every - 1));
            end
        end
    endtask

    initial begin
        int basic_lit [9];
        int odd_lit [9];
        int d;
        basic_lit = '{0, 32767, 0, -32767, 0, 32767, 0, -32767, 0};
        odd_lit   = '{0, 32767, 0, -32767, 0, 32767, 0, -32767, 0};
        for (int k = 0; k < DEPTH; k++) tab[k] = ref_sine(k);

        chk("pin_tab0",   tab[0],   0);
        chk("pin_tab64",  tab[64],  32767);
        chk("pin_tab192", tab[192], -32767);
        chk("pin_tab255", tab[255], -804);
        chk("pin_tab254", tab[254], -1608);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Basic run, ready held high.
        run_case(4, 2, 64, 1'b0);
        check_seq("basic", basic_lit, 8, 4);

        // Same run under random backpressure.
        run_case(4, 2, 64, 1'b1);
        check_seq("bp", basic_lit, 8, 4);

        // Odd frame length: phase continues across frames.
        run_case(3, 3, 64, 1'b0);
        check_seq("odd", odd_lit, 9, 3);

        // Phase wrap-around.
        run_case(3, 1, 255, 1'b0);
        if (cap_q.size() == 3) begin
            chk("wrap_b0", cap_q[0], 0);
            d = cap_q[1] + 804;
            chk("wrap_b1_tol", int'(d >= -1 && d <= 1), 1);
            d = cap_q[2] + 1608;
            chk("wrap_b2_tol", int'(d >= -1 && d <= 1), 1);
        end

        // Degenerate starts: done next cycle, no beats.
        run_case(0, 2, 64, 1'b0);
        run_case(5, 0, 64, 1'b1);

        // Start while busy is ignored.
        cap_q.delete();
        capl_q.delete();
        done_seen = 1'b0;
        rdy_mode  = 1'b1;
        pulse_start(4, 3, 64);
        wait_beats(2, 100);
        pulse_start(2, 1, 32);
        wait_done(200);
        chk("busy_start_beats", cap_q.size(), 12);
        $display("start-while-busy beats=%0d", cap_q.size());

        // Reset in the middle of a run.
        cap_q.delete();
        capl_q.delete();
        done_seen = 1'b0;
        rdy_mode  = 1'b0;
        pulse_start(16, 1, 16);
        wait_beats(3, 100);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_no_done", int'(done_seen), 0);
        $display("reset mid-run after %0d beats", cap_q.size());
        run_case(4, 1, 64, 1'b0);
        if (cap_q.size() >= 2) begin
            chk("post_reset_b0", cap_q[0], 0);
            chk("post_reset_b1", cap_q[1], 32767);
        end

        // Randomised runs.
        for (int r = 0; r < 8; r++) begin
            run_case($urandom_range(1, 7), $urandom_range(1, 4), $urandom_range(0, 255),
                     1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
